// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - load handshake and serial beat bundle for piso_serializer
interface piso_serializer_if #(
    parameter int WIDTH = 32
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] x;
    logic             load_valid;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             sout_ready;
    logic             sout_last;
    logic             done;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output x, load_valid, sout_ready,
        input  load_ready, sout, sout_valid, sout_last, done, bit_cnt
    );

    modport slave (
        input  x, load_valid, sout_ready,
        output load_ready, sout, sout_valid, sout_last, done, bit_cnt
    );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with bit-level backpressure
module piso_serializer #(
    parameter int WIDTH     = 32,
    parameter bit LSB_FIRST = 1'b0
) (
    input logic              clk,
    input logic              rst,
    piso_serializer_if.slave bus
);
    localparam int                 CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   PENULT_CNT = CNT_W'(WIDTH - 2);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             load_ready_q;
    logic             sout_valid_q;
    logic             sout_last_q;
    logic             done_q;

    // Shift toward the output end with zero fill, so shreg is all zeros once a word has drained.
    generate
        if (LSB_FIRST) begin : g_lsb
            assign shreg_d  = {1'b0, shreg_q[WIDTH-1:1]};
            assign bus.sout = sout_valid_q & shreg_q[0];
        end else begin : g_msb
            assign shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
            assign bus.sout = sout_valid_q & shreg_q[WIDTH-1];
        end
    endgenerate

    // sout_last is precomputed one beat ahead so it is a register, not a compare on bit_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            load_ready_q <= 1'b1;
            sout_valid_q <= 1'b0;
            sout_last_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.load_valid && load_ready_q) begin
                        shreg_q      <= bus.x;
                        bit_cnt_q    <= '0;
                        state_q      <= SHIFT;
                        load_ready_q <= 1'b0;
                        sout_valid_q <= 1'b1;
                        sout_last_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bus.sout_ready) begin
                        shreg_q <= shreg_d;
                        if (sout_last_q) begin
                            state_q      <= IDLE;
                            bit_cnt_q    <= '0;
                            load_ready_q <= 1'b1;
                            sout_valid_q <= 1'b0;
                            sout_last_q  <= 1'b0;
                            done_q       <= 1'b1;
                        end else begin
                            bit_cnt_q   <= bit_cnt_q + CNT_W'(1);
                            sout_last_q <= (bit_cnt_q == PENULT_CNT);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.sout_valid = sout_valid_q;
    assign bus.sout_last  = sout_last_q;
    assign bus.done       = done_q;
    assign bus.bit_cnt    = bit_cnt_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer
module tb_piso_serializer;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(W)) if0 ();
    piso_serializer_if #(.WIDTH(W)) if1 ();

    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    int total = 0;
    int bad   = 0;
    logic [W-1:0] sbits;

    function automatic logic [W-1:0] model_stream(input logic [W-1:0] w, input bit lsb);
        logic [W-1:0] s;
        for (int k = 0; k < W; k++) s[k] = lsb ? w[k] : w[W-1-k];
        return s;
    endfunction

    task automatic set_load(input int sel, input logic lv, input logic [W-1:0] xv);
        if (sel == 0) begin if0.load_valid = lv; if0.x = xv; end
        else          begin if1.load_valid = lv; if1.x = xv; end
    endtask

    task automatic set_ready(input int sel, input logic r);
        if (sel == 0) if0.sout_ready = r; else if1.sout_ready = r;
    endtask

    task automatic rd(input int sel, output logic sv, output logic so, output logic sl,
                      output logic dn, output logic lr, output logic [4:0] bc);
        if (sel == 0) begin sv = if0.sout_valid; so = if0.sout; sl = if0.sout_last; dn = if0.done; lr = if0.load_ready; bc = if0.bit_cnt; end
        else          begin sv = if1.sout_valid; so = if1.sout; sl = if1.sout_last; dn = if1.done; lr = if1.load_ready; bc = if1.bit_cnt; end
    endtask

    task automatic load(input int sel, input logic [W-1:0] w, output logic lr);
        lr = (sel == 0) ? if0.load_ready : if1.load_ready;
        set_load(sel, 1'b1, w);
        @(negedge clk);
        set_load(sel, 1'b0, w);
    endtask

    // Acts as the serial sink: counts protocol violations and reassembles the word.
    task automatic stream(input int sel, input bit rnd, input int maxb, output logic [W-1:0] got,
                          output int beats, output int errs, output int dones,
                          output logic end_done, output logic end_lr, output bit timeout);
        logic sv, so, sl, dn, lr, rr, prev_bit;
        logic [4:0] bc;
        bit prev_stall;
        got = '0; beats = 0; errs = 0; dones = 0; end_done = 1'b0; end_lr = 1'b0;
        timeout = 1'b1; prev_stall = 1'b0; prev_bit = 1'b0; sbits = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rd(sel, sv, so, sl, dn, lr, bc);
            if (dn) dones++;
            if (sv) begin
                if (bc !== 5'(beats)) errs++;
                if (sl !== (beats == W - 1)) errs++;
                if (lr !== 1'b0) errs++;
                if (prev_stall && so !== prev_bit) errs++;
            end else begin
                errs++;
            end
            rr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            set_ready(sel, rr);
            prev_stall = sv && !rr;
            prev_bit = so;
            @(negedge clk);
            if (rr && sv) begin
                sbits[beats] = so;
                if (sel == 1) got[beats] = so;
                else          got = {got[W-2:0], so};
                beats++;
            end
            if (beats == maxb) begin
                set_ready(sel, 1'b0);
                if (maxb == W) begin
                    rd(sel, sv, so, sl, dn, lr, bc);
                    end_done = dn;
                    end_lr = lr;
                    if (sv !== 1'b0) errs++;
                end
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_load(0, 1'b1, 32'd10); set_load(1, 1'b1, 32'd10);
        set_ready(0, 1'b0); set_ready(1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if ({if0.sout_valid, if0.sout, if0.done, if1.sout_valid, if1.sout, if1.done} !== 6'b0) begin
                bad++; $display("FAIL reset_outputs cycle %0d: got %b, want 000000", i,
                    {if0.sout_valid, if0.sout, if0.done, if1.sout_valid, if1.sout, if1.done});
            end
        end
        rst = 1'b0;
        set_load(0, 1'b0, '0); set_load(1, 1'b0, '0);
        @(negedge clk);
        total++;
        if ({if0.load_ready, if0.sout_valid, if0.bit_cnt, if1.load_ready, if1.sout_valid} !== {1'b1, 1'b0, 5'd0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL reset_release: got lr=%b sv=%b cnt=%0d lr1=%b sv1=%b, want 1 0 0 1 0",
                if0.load_ready, if0.sout_valid, if0.bit_cnt, if1.load_ready, if1.sout_valid);
        end
    endtask

    task automatic test_msb_first;
        logic lr, ed, el; logic [W-1:0] got; int beats, errs, dones; bit to;
        load(0, 32'd10, lr);
        total++; if (lr !== 1'b1) begin bad++; $display("FAIL msb_load_ready: got %b want 1", lr); end
        stream(0, 1'b0, W, got, beats, errs, dones, ed, el, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL msb_timeout: beats=%0d want 32", beats); end
        total++; if (got !== 32'd10) begin bad++; $display("FAIL msb_word: got %0d want 10", got); end
        total++; if ({sbits[28], sbits[29], sbits[30], sbits[31]} !== 4'b1010) begin
            bad++; $display("FAIL msb_bits28_31: got %b want 1010", {sbits[28], sbits[29], sbits[30], sbits[31]}); end
        total++; if (sbits !== model_stream(32'd10, 1'b0)) begin
            bad++; $display("FAIL msb_stream: got %h want %h", sbits, model_stream(32'd10, 1'b0)); end
        total++; if (errs !== 0) begin bad++; $display("FAIL msb_protocol: got %0d errors want 0", errs); end
        total++; if (dones !== 0 || ed !== 1'b1 || el !== 1'b1) begin
            bad++; $display("FAIL msb_done: early=%0d done=%b lr=%b want 0 1 1", dones, ed, el); end
        @(negedge clk);
        total++; if (if0.done !== 1'b0 || if0.load_ready !== 1'b1) begin
            bad++; $display("FAIL msb_done_width: done=%b lr=%b want 0 1", if0.done, if0.load_ready); end
    endtask

    task automatic test_lsb_first;
        logic lr, ed, el; logic [W-1:0] got; int beats, errs, dones; bit to;
        load(1, 32'd91, lr);
        stream(1, 1'b0, W, got, beats, errs, dones, ed, el, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL lsb_timeout: beats=%0d want 32", beats); end
        total++; if (sbits[7:0] !== 8'h5B || sbits[31:8] !== 24'h0) begin
            bad++; $display("FAIL lsb_bits: got %h want 0000005b", sbits); end
        total++; if (got !== 32'd91) begin bad++; $display("FAIL lsb_word: got %0d want 91", got); end
        total++; if (errs !== 0 || dones !== 0 || ed !== 1'b1) begin
            bad++; $display("FAIL lsb_protocol: errs=%0d early=%0d done=%b want 0 0 1", errs, dones, ed); end
        @(negedge clk);
        total++; if (if1.done !== 1'b0) begin bad++; $display("FAIL lsb_done_width: got %b want 0", if1.done); end
    endtask

    task automatic test_backpressure;
        logic lr, ed, el; logic [W-1:0] got; int beats, errs, dones; bit to;
        load(0, 32'd56, lr);
        stream(0, 1'b1, W, got, beats, errs, dones, ed, el, to);
        total++; if (to !== 1'b0 || beats !== W) begin bad++; $display("FAIL bp_beats: got %0d want 32", beats); end
        total++; if (got !== 32'd56) begin bad++; $display("FAIL bp_word: got %0d want 56", got); end
        total++; if (errs !== 0) begin bad++; $display("FAIL bp_stall_protocol: got %0d errors want 0", errs); end
        total++; if (dones !== 0 || ed !== 1'b1) begin bad++; $display("FAIL bp_done: early=%0d done=%b want 0 1", dones, ed); end
        @(negedge clk);
    endtask

    task automatic test_load_while_busy;
        logic lr, ed, el; logic [W-1:0] got; int beats, errs, dones; bit to;
        load(0, 32'd10, lr);
        set_load(0, 1'b1, 32'd91);
        stream(0, 1'b0, W, got, beats, errs, dones, ed, el, to);
        total++; if (got !== 32'd10 || to !== 1'b0) begin bad++; $display("FAIL busy_word: got %0d want 10", got); end
        total++; if (errs !== 0 || ed !== 1'b1 || el !== 1'b1) begin
            bad++; $display("FAIL busy_protocol: errs=%0d done=%b lr=%b want 0 1 1", errs, ed, el); end
        @(negedge clk);
        set_load(0, 1'b0, '0);
        total++; if (if0.sout_valid !== 1'b1 || if0.bit_cnt !== 5'd0 || if0.load_ready !== 1'b0) begin
            bad++; $display("FAIL busy_next_accept: sv=%b cnt=%0d lr=%b want 1 0 0", if0.sout_valid, if0.bit_cnt, if0.load_ready); end
        stream(0, 1'b0, W, got, beats, errs, dones, ed, el, to);
        total++; if (got !== 32'd91 || errs !== 0 || to !== 1'b0) begin
            bad++; $display("FAIL busy_second_word: got %0d errs=%0d want 91 0", got, errs); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_word;
        logic lr, ed, el; logic [W-1:0] got; int beats, errs, dones; bit to;
        load(0, 32'd56, lr);
        stream(0, 1'b0, 12, got, beats, errs, dones, ed, el, to);
        total++; if (beats !== 12 || sbits[11:0] !== model_stream(32'd56, 1'b0)[11:0]) begin
            bad++; $display("FAIL mid_partial: beats=%0d bits=%h want 12 %h", beats, sbits[11:0], model_stream(32'd56, 1'b0)[11:0]); end
        rst = 1'b1;
        set_ready(0, 1'b1);
        @(negedge clk);
        total++; if ({if0.sout_valid, if0.sout, if0.sout_last, if0.done, if0.bit_cnt} !== 9'b0) begin
            bad++; $display("FAIL mid_reset_outputs: got %b want 000000000",
                {if0.sout_valid, if0.sout, if0.sout_last, if0.done, if0.bit_cnt}); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (if0.done !== 1'b0 || if0.load_ready !== 1'b1 || if0.sout_valid !== 1'b0) begin
            bad++; $display("FAIL mid_after_release: done=%b lr=%b sv=%b want 0 1 0", if0.done, if0.load_ready, if0.sout_valid); end
        load(0, 32'd91, lr);
        stream(0, 1'b0, W, got, beats, errs, dones, ed, el, to);
        total++; if (got !== 32'd91 || sbits !== model_stream(32'd91, 1'b0) || errs !== 0 || ed !== 1'b1) begin
            bad++; $display("FAIL mid_reload: got %0d errs=%0d done=%b want 91 0 1", got, errs, ed); end
        @(negedge clk);
    endtask

    task automatic test_random_words;
        logic lr, ed, el; logic [W-1:0] got, w; int beats, errs, dones; bit to;
        for (int i = 0; i < 8; i++) begin
            int sel;
            sel = i % 2;
            w = $urandom;
            load(sel, w, lr);
            stream(sel, 1'b1, W, got, beats, errs, dones, ed, el, to);
            total++; if (got !== w || sbits !== model_stream(w, sel == 1)) begin
                bad++; $display("FAIL rand_word %0d sel=%0d: got %h stream %h want %h stream %h", i, sel, got, sbits, w, model_stream(w, sel == 1)); end
            total++; if (errs !== 0 || dones !== 0 || ed !== 1'b1 || to !== 1'b0) begin
                bad++; $display("FAIL rand_protocol %0d: errs=%0d early=%0d done=%b to=%b want 0 0 1 0", i, errs, dones, ed, to); end
            @(negedge clk);
        end
    endtask

    initial begin
        set_load(0, 1'b0, '0); set_load(1, 1'b0, '0);
        set_ready(0, 1'b0); set_ready(1, 1'b0);
        rst = 1'b1;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_backpressure();
        test_load_while_busy();
        test_reset_mid_word();
        test_random_words();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
